sc_instr_encoder: RTL



---
 rtl/sc_instr_encoder_if.sv | 41 ++++
 rtl/sc_instr_encoder.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/sc_instr_encoder_if.sv
// Bus bundle for sc_instr_encoder: decoded instruction fields and start/clear in,
// instruction-memory write port and status out.
interface sc_instr_encoder_if #(
  parameter int unsigned ADDRWIDTH     = 8,
  parameter int unsigned DATAWIDTH_BUS = 32
);
  logic                     SC_InstrEnc_Start_InHigh;
  logic                     SC_InstrEnc_Clear_InHigh;
  logic [1:0]               SC_InstrEnc_OP;
  logic [4:0]               SC_InstrEnc_RD;
  logic [2:0]               SC_InstrEnc_OP2;
  logic [5:0]               SC_InstrEnc_OP3;
  logic [4:0]               SC_InstrEnc_RS1;
  logic                     SC_InstrEnc_BIT13;
  logic [4:0]               SC_InstrEnc_RS2;
  logic [29:0]              SC_InstrEnc_IMM;
  logic                     SC_InstrEnc_MemAck_InHigh;
  logic                     SC_InstrEnc_Ready;
  logic                     SC_InstrEnc_MemWrite_InHigh;
  logic [ADDRWIDTH-1:0]     SC_InstrEnc_MemAddr;
  logic [DATAWIDTH_BUS-1:0] SC_InstrEnc_MemData;
  logic                     SC_InstrEnc_Done;
  logic                     SC_InstrEnc_Err;
  logic                     SC_InstrEnc_Full;

  modport master (
    output SC_InstrEnc_Start_InHigh, SC_InstrEnc_Clear_InHigh, SC_InstrEnc_OP, SC_InstrEnc_RD,
           SC_InstrEnc_OP2, SC_InstrEnc_OP3, SC_InstrEnc_RS1, SC_InstrEnc_BIT13, SC_InstrEnc_RS2,
           SC_InstrEnc_IMM, SC_InstrEnc_MemAck_InHigh,
    input  SC_InstrEnc_Ready, SC_InstrEnc_MemWrite_InHigh, SC_InstrEnc_MemAddr, SC_InstrEnc_MemData,
           SC_InstrEnc_Done, SC_InstrEnc_Err, SC_InstrEnc_Full
  );

  modport slave (
    input  SC_InstrEnc_Start_InHigh, SC_InstrEnc_Clear_InHigh, SC_InstrEnc_OP, SC_InstrEnc_RD,
           SC_InstrEnc_OP2, SC_InstrEnc_OP3, SC_InstrEnc_RS1, SC_InstrEnc_BIT13, SC_InstrEnc_RS2,
           SC_InstrEnc_IMM, SC_InstrEnc_MemAck_InHigh,
    output SC_InstrEnc_Ready, SC_InstrEnc_MemWrite_InHigh, SC_InstrEnc_MemAddr, SC_InstrEnc_MemData,
           SC_InstrEnc_Done, SC_InstrEnc_Err, SC_InstrEnc_Full
  );
endinterface

// File: rtl/sc_instr_encoder.sv
// Packs decoded SPARC instruction fields into a 32-bit word, range-checks the immediate
// and stores it into instruction memory at an auto-incrementing word address.
module sc_instr_encoder #(
  parameter int unsigned DATAWIDTH_BUS = 32,
  parameter int unsigned ADDRWIDTH     = 8,
  parameter int unsigned DEPTH         = 256
) (
  input logic               SC_InstrEnc_CLOCK_50,
  input logic               SC_InstrEnc_Reset_InLow,
  sc_instr_encoder_if.slave encBus
);
  localparam int unsigned          IMMWIDTH = 30;
  localparam logic [ADDRWIDTH-1:0] LASTADDR = ADDRWIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {
    STATE_IDLE,
    STATE_ENCODE,
    STATE_ERR,
    STATE_WRITE,
    STATE_DONE
  } state_t;

  state_t                   stateQ, stateNext;
  logic [1:0]               opQ;
  logic [4:0]               rdQ, rs1Q, rs2Q;
  logic [2:0]               op2Q;
  logic [5:0]               op3Q;
  logic                     bit13Q;
  logic [IMMWIDTH-1:0]      immQ;
  logic [ADDRWIDTH-1:0]     addrQ, addrNext;
  logic [DATAWIDTH_BUS-1:0] dataQ, dataNext, encWord;
  logic                     fullQ, fullNext;
  logic                     latchEn, encErr;
  logic                     memWriteQ, doneQ, errQ;

  // Word assembly and immediate range check from the latched fields
  always_comb begin
    encWord = '0;
    encErr  = 1'b0;
    case (opQ)
      2'b01: encWord = {2'b01, immQ};
      2'b00: begin
        encWord = {2'b00, rdQ, op2Q, immQ[21:0]};
        encErr  = |immQ[29:22];
      end
      default: begin
        if (bit13Q) begin
          encWord = {opQ, rdQ, op3Q, rs1Q, 1'b1, immQ[12:0]};
          // simm13 fits only when bits 29..12 are a pure sign extension
          encErr  = !((&immQ[29:12]) || !(|immQ[29:12]));
        end else begin
          encWord = {opQ, rdQ, op3Q, rs1Q, 1'b0, 8'b0, rs2Q};
        end
      end
    endcase
  end

  always_comb begin
    stateNext = stateQ;
    addrNext  = addrQ;
    dataNext  = dataQ;
    fullNext  = fullQ;
    latchEn   = 1'b0;
    case (stateQ)
      STATE_IDLE: begin
        if (encBus.SC_InstrEnc_Clear_InHigh) begin
          addrNext = '0;
          fullNext = 1'b0;
        end else if (encBus.SC_InstrEnc_Start_InHigh && !fullQ) begin
          latchEn   = 1'b1;
          stateNext = STATE_ENCODE;
        end
      end
      STATE_ENCODE: begin
        if (encErr) begin
          stateNext = STATE_ERR;
        end else begin
          dataNext  = encWord;
          stateNext = STATE_WRITE;
        end
      end
      STATE_ERR:   stateNext = STATE_IDLE;
      STATE_WRITE: if (encBus.SC_InstrEnc_MemAck_InHigh) stateNext = STATE_DONE;
      STATE_DONE: begin
        if (addrQ == LASTADDR) begin
          addrNext = '0;
          fullNext = 1'b1;
        end else begin
          addrNext = addrQ + ADDRWIDTH'(1);
        end
        stateNext = STATE_IDLE;
      end
      default: stateNext = STATE_IDLE;
    endcase
  end

  // Control state and registered outputs, all on the falling edge
  always_ff @(negedge SC_InstrEnc_CLOCK_50 or negedge SC_InstrEnc_Reset_InLow) begin
    if (!SC_InstrEnc_Reset_InLow) begin
      stateQ    <= STATE_IDLE;
      addrQ     <= '0;
      dataQ     <= '0;
      fullQ     <= 1'b0;
      memWriteQ <= 1'b0;
      doneQ     <= 1'b0;
      errQ      <= 1'b0;
    end else begin
      stateQ    <= stateNext;
      addrQ     <= addrNext;
      dataQ     <= dataNext;
      fullQ     <= fullNext;
      memWriteQ <= (stateNext == STATE_WRITE);
      doneQ     <= (stateNext == STATE_DONE);
      errQ      <= (stateNext == STATE_ERR);
    end
  end

  // Field capture so inputs may change once Start has been accepted
  always_ff @(negedge SC_InstrEnc_CLOCK_50 or negedge SC_InstrEnc_Reset_InLow) begin
    if (!SC_InstrEnc_Reset_InLow) begin
      opQ    <= '0;
      rdQ    <= '0;
      op2Q   <= '0;
      op3Q   <= '0;
      rs1Q   <= '0;
      bit13Q <= 1'b0;
      rs2Q   <= '0;
      immQ   <= '0;
    end else if (latchEn) begin
      opQ    <= encBus.SC_InstrEnc_OP;
      rdQ    <= encBus.SC_InstrEnc_RD;
      op2Q   <= encBus.SC_InstrEnc_OP2;
      op3Q   <= encBus.SC_InstrEnc_OP3;
      rs1Q   <= encBus.SC_InstrEnc_RS1;
      bit13Q <= encBus.SC_InstrEnc_BIT13;
      rs2Q   <= encBus.SC_InstrEnc_RS2;
      immQ   <= encBus.SC_InstrEnc_IMM;
    end
  end

  assign encBus.SC_InstrEnc_Ready           = (stateQ == STATE_IDLE) && !fullQ;
  assign encBus.SC_InstrEnc_MemWrite_InHigh = memWriteQ;
  assign encBus.SC_InstrEnc_MemAddr         = addrQ;
  assign encBus.SC_InstrEnc_MemData         = dataQ;
  assign encBus.SC_InstrEnc_Done            = doneQ;
  assign encBus.SC_InstrEnc_Err             = errQ;
  assign encBus.SC_InstrEnc_Full            = fullQ;
endmodule
